seq_multiplier: RTL

//   Parametrised radix-2 shift-add multiplier; successor to the 8x8 combinational array multiplier.

---
 rtl/mult_pkg.sv | 25 ++
 rtl/cond_neg.sv | 20 ++
 rtl/seq_multiplier.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
//   Shared definitions for the sequential shift-add multiplier.
//   - state_t : FSM state encoding (IDLE=0, BUSY=1, DONE=2)
//   - clog2() : width of the iteration counter for a given operand width
// -----------------------------------------------------------------------------
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Ceiling log2, never less than 1 so a counter always has at least one bit.
   function automatic int clog2(input int value);
      int result;
      result = 1;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage : mult_pkg

// File: rtl/cond_neg.sv
// -----------------------------------------------------------------------------
// cond_neg
//   Conditional two's-complement negation: y_o = neg_i ? -x_i : x_i (mod 2^N).
//   Used both to take operand magnitudes and to restore the product sign.
// Ports
//   x_i   in  N  value
//   neg_i in  1  negate when 1
//   y_o   out N  result
// -----------------------------------------------------------------------------
module cond_neg #(
   parameter int N = 8
) (
   input  logic [N-1:0] x_i,
   input  logic         neg_i,
   output logic [N-1:0] y_o
);

   assign y_o = neg_i ? (~x_i + N'(1)) : x_i;

endmodule : cond_neg

// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
//   Radix-2 shift-add multiplier retiring one multiplier bit per clock.
//   Signed operands are multiplied as magnitudes and the sign is re-applied
//   on the final iteration. Valid/ready handshake on input and output.
// Ports
//   clk        in   1         rising-edge clock
//   rst        in   1         asynchronous active-high reset
//   in_valid   in   1         operands and mode presented
//   in_ready   out  1         idle, operands can be accepted
//   a          in   WIDTH     multiplicand
//   b          in   WIDTH     multiplier
//   signed_md  in   1         1: two's complement operands, 0: unsigned
//   out_valid  out  1         product valid, held until accepted
//   out_ready  in   1         downstream accepts product
//   product    out  2*WIDTH   result
// -----------------------------------------------------------------------------
module seq_multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 signed_md,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = clog2(WIDTH);
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   state_t            state_q,   state_d;
   logic [CW-1:0]     count_q,   count_d;
   logic [PW-1:0]     acc_q,     acc_d;
   logic [PW-1:0]     mcand_q,   mcand_d;
   logic [WIDTH-1:0]  mplr_q,    mplr_d;
   logic              neg_q,     neg_d;
   logic [PW-1:0]     product_q, product_d;

   logic [WIDTH-1:0]  mag_a;
   logic [WIDTH-1:0]  mag_b;
   logic [PW-1:0]     acc_sum;
   logic [PW-1:0]     signed_result;

   // Operand magnitudes. |-2^(W-1)| wraps to 2^(W-1), which is exactly the
   // right unsigned magnitude, so no extra bit is needed.
   cond_neg #(.N(WIDTH)) u_abs_a (
      .x_i   (a),
      .neg_i (signed_md & a[WIDTH-1]),
      .y_o   (mag_a)
   );

   cond_neg #(.N(WIDTH)) u_abs_b (
      .x_i   (b),
      .neg_i (signed_md & b[WIDTH-1]),
      .y_o   (mag_b)
   );

   // Accumulator after this iteration's conditional add; the final iteration
   // feeds it straight into the sign restore so no extra cycle is spent.
   assign acc_sum = acc_q + (mplr_q[0] ? mcand_q : '0);

   cond_neg #(.N(PW)) u_sign_fix (
      .x_i   (acc_sum),
      .neg_i (neg_q),
      .y_o   (signed_result)
   );

   always_comb begin
      // NOTE: every next-state signal gets its hold value first, so no path
      // through the case leaves one unassigned and no latch is inferred.
      state_d   = state_q;
      count_d   = count_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplr_d    = mplr_q;
      neg_d     = neg_q;
      product_d = product_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               mcand_d = {{WIDTH{1'b0}}, mag_a};
               mplr_d  = mag_b;
               acc_d   = '0;
               count_d = '0;
               neg_d   = signed_md & (a[WIDTH-1] ^ b[WIDTH-1]);
               state_d = BUSY;
            end
         end

         BUSY: begin
            acc_d   = acc_sum;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            count_d = count_q + CW'(1);
            if (count_q == LAST_ITER) begin
               product_d = signed_result;
               state_d   = DONE;
            end
         end

         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: every datapath register is reset, not just the FSM, because the
   // product must read zero during and after reset; an abandoned operation
   // must leave nothing behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         count_q   <= '0;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplr_q    <= '0;
         neg_q     <= 1'b0;
         product_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so all registers update from the
         // same pre-edge values regardless of statement order.
         state_q   <= state_d;
         count_q   <= count_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplr_q    <= mplr_d;
         neg_q     <= neg_d;
         product_q <= product_d;
      end
   end

   // The IDLE state register is already IDLE while reset is held, so ready is
   // also gated by rst to keep the source from handing over operands then.
   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign product   = product_q;

endmodule : seq_multiplier
